sequence_generator: RTL and testbench

Serial bit-stream transmitter: the write side of the team's serial sequence detectors. It takes a parallel pattern through a load/ready handshake and shifts it out MSB-first on x, one bit per clock. Each accepted pattern is sent repeat+1 times back-to-back, and done pulses at the end. It drives the x input of any detector in the lab and also serves as its bench stimulus source.

---
 rtl/sequence_pkg.sv | 21 ++
 rtl/bit_index_counter.sv | 63 ++++++
 rtl/sequence_generator.sv | 133 +++++++++++++
 tb/tb_sequence_generator.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_pkg.sv
// Shared definitions for the serial sequence generator: default sizes,
// FSM state encoding and the pattern-length clamp.
package sequence_pkg;

    localparam int unsigned SEQ_MAX_LEN = 16;
    localparam int unsigned SEQ_LEN_W   = 5;
    localparam int unsigned SEQ_REP_W   = 4;

    // Encoding 2'b11 is deliberately left unnamed; the FSM recovers to IDLE from it.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } state_t;

    // Requested lengths above the pattern register width are limited to that width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/bit_index_counter.sv
// Bit-index down-counter with wrap-to-load-value and a pass counter.
// r_idx always points at the bit currently on the line; the next value is
// exported so the top level can register the matching data bit.
module bit_index_counter #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [IDX_W-1:0] i_load_idx,
    input  logic [REP_W-1:0] i_load_pass,
    input  logic             i_en,
    output logic [IDX_W-1:0] o_idx_next_c,
    output logic             o_last_bit_c,
    output logic             o_last_pass_c
);

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_wrap;
    logic [REP_W-1:0] r_pass;

    logic [IDX_W-1:0] w_idx_next;
    logic [IDX_W-1:0] w_wrap_next;
    logic [REP_W-1:0] w_pass_next;

    // Next-value logic: load wins, otherwise step down and wrap between passes.
    always_comb begin
        w_idx_next  = r_idx;
        w_wrap_next = r_wrap;
        w_pass_next = r_pass;
        if (i_load) begin
            w_idx_next  = i_load_idx;
            w_wrap_next = i_load_idx;
            w_pass_next = i_load_pass;
        end else if (i_en) begin
            if (r_idx != '0) begin
                w_idx_next = r_idx - IDX_W'(1);
            end else if (r_pass != '0) begin
                w_idx_next  = r_wrap;
                w_pass_next = r_pass - REP_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx  <= '0;
            r_wrap <= '0;
            r_pass <= '0;
        end else begin
            r_idx  <= w_idx_next;
            r_wrap <= w_wrap_next;
            r_pass <= w_pass_next;
        end
    end

    assign o_idx_next_c  = w_idx_next;
    assign o_last_bit_c  = (r_idx == '0);
    assign o_last_pass_c = (r_pass == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serial bit-stream transmitter: accepts a pattern through load/ready and
// shifts it out MSB-first on o_x, repeat+1 passes back-to-back, then pulses done.
module sequence_generator
    import sequence_pkg::*;
#(
    parameter int unsigned MAX_LEN = SEQ_MAX_LEN,
    parameter int unsigned LEN_W   = SEQ_LEN_W,
    parameter int unsigned REP_W   = SEQ_REP_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_length,
    input  logic [REP_W-1:0]   i_repeat,
    input  logic               i_hold,
    output logic               o_ready,
    output logic               o_x,
    output logic               o_x_valid,
    output logic               o_done,
    output logic [1:0]         o_s
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [MAX_LEN-1:0] r_pattern;
    logic [MAX_LEN-1:0] w_pat_src;
    logic [LEN_W-1:0]   w_len_in;
    logic [IDX_W-1:0]   w_load_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic               w_accept;
    logic               w_cnt_en;
    logic               w_last_bit;
    logic               w_last_pass;
    logic               w_ready_next;
    logic               w_x_next;
    logic               w_x_valid_next;
    logic               w_done_next;

    assign w_accept   = (r_state == IDLE) && i_load;
    assign w_cnt_en   = (r_state == SEND) && !i_hold;
    assign w_len_in   = LEN_W'(clamp_len(32'(i_length), MAX_LEN));
    assign w_load_idx = IDX_W'(w_len_in - LEN_W'(1));
    // On the accepting edge the pattern register is not yet loaded, so use the input.
    assign w_pat_src  = w_accept ? i_pattern : r_pattern;

    bit_index_counter #(
        .IDX_W (IDX_W),
        .REP_W (REP_W)
    ) u_bit_index_counter (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_load        (w_accept),
        .i_load_idx    (w_load_idx),
        .i_load_pass   (i_repeat),
        .i_en          (w_cnt_en),
        .o_idx_next_c  (w_idx_next),
        .o_last_bit_c  (w_last_bit),
        .o_last_pass_c (w_last_pass)
    );

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        w_state_next   = r_state;
        w_ready_next   = 1'b0;
        w_x_next       = 1'b0;
        w_x_valid_next = 1'b0;
        w_done_next    = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_state_next = (w_len_in == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (!i_hold && w_last_bit && w_last_pass) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_ready_next   = (w_state_next == IDLE);
        w_done_next    = (w_state_next == DONE);
        // A held edge leaves the index in place and presents no valid bit.
        w_x_valid_next = (w_state_next == SEND) && ((r_state != SEND) || !i_hold);
        w_x_next       = w_x_valid_next ? w_pat_src[w_idx_next] : 1'b0;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pattern capture on accept; later input changes have no effect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pattern <= '0;
        end else if (w_accept) begin
            r_pattern <= i_pattern;
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ready   <= 1'b1;
            o_x       <= 1'b0;
            o_x_valid <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_ready   <= w_ready_next;
            o_x       <= w_x_next;
            o_x_valid <= w_x_valid_next;
            o_done    <= w_done_next;
        end
    end

    assign o_s = r_state;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: each task drives one scenario and
// compares the observed serial stream against hand-computed values.
module tb_sequence_generator;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] pattern;
    logic [4:0]  length;
    logic [3:0]  rep;
    logic        hold;
    logic        ready;
    logic        x;
    logic        xv;
    logic        done;
    logic [1:0]  s;

    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle capture of one transfer, cycle 1 = first cycle after accept.
    logic [79:0] cap_bits;
    int          cap_nbits;
    int          cap_done_cyc;
    int          cap_last;
    logic        cap_valid [1:80];
    logic        cap_x     [1:80];
    logic        cap_ready [1:80];
    logic        cap_done  [1:80];
    logic [1:0]  cap_s     [1:80];

    sequence_generator dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_load    (load),
        .i_pattern (pattern),
        .i_length  (length),
        .i_repeat  (rep),
        .i_hold    (hold),
        .o_ready   (ready),
        .o_x       (x),
        .o_x_valid (xv),
        .o_done    (done),
        .o_s       (s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no summary want summary");
        $fatal(1, "time limit");
    end

    // Start a transfer at a negedge and record outputs until one cycle after done.
    task automatic run_xfer(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r,
                            input int hs, input int hl, input int la, input logic [15:0] alt);
        cap_bits     = '0;
        cap_nbits    = 0;
        cap_done_cyc = -1;
        cap_last     = 0;
        for (int i = 1; i <= 80; i++) begin
            cap_valid[i] = 1'b0;
            cap_x[i]     = 1'b0;
            cap_ready[i] = 1'b0;
            cap_done[i]  = 1'b0;
            cap_s[i]     = 2'b00;
        end
        load    = 1'b1;
        pattern = p;
        length  = l;
        rep     = r;
        hold    = 1'b0;
        @(negedge clk);
        load    = 1'b0;
        pattern = ~p;
        length  = 5'd7;
        rep     = ~r;
        for (int k = 1; k <= 80; k++) begin
            cap_valid[k] = xv;
            cap_x[k]     = x;
            cap_ready[k] = ready;
            cap_done[k]  = done;
            cap_s[k]     = s;
            cap_last     = k;
            if (xv === 1'b1) begin
                cap_bits  = {cap_bits[78:0], x};
                cap_nbits = cap_nbits + 1;
            end
            if (done === 1'b1 && cap_done_cyc < 0) cap_done_cyc = k;
            if (cap_done_cyc >= 0 && k > cap_done_cyc) break;
            load    = (k == la);
            pattern = (k == la) ? alt : ~p;
            hold    = (k >= hs && k < hs + hl);
            @(negedge clk);
        end
        load = 1'b0;
        hold = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        load    = 1'b0;
        hold    = 1'b0;
        pattern = '0;
        length  = '0;
        rep     = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ready, x, xv, done, s} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy,x,xv,done,S=%b want 100000", {ready, x, xv, done, s});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || s !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got ready=%b S=%b want ready=1 S=00", ready, s);
        end
    endtask

    task automatic test_basic();
        int busy;
        run_xfer(16'h000B, 5'd4, 4'd0, 99, 0, 0, 16'h0000);
        n_cmp++;
        if (cap_bits !== 80'hB || cap_nbits != 4) begin
            n_err++;
            $display("FAIL basic_bits: got %h/%0d want b/4", cap_bits, cap_nbits);
        end
        n_cmp++;
        if (cap_done_cyc != 5) begin
            n_err++;
            $display("FAIL basic_done_cycle: got %0d want 5", cap_done_cyc);
        end
        busy = 0;
        for (int k = 1; k <= 5; k++) busy += int'(cap_ready[k]);
        n_cmp++;
        if (busy != 0 || cap_ready[6] !== 1'b1 || cap_done[6] !== 1'b0) begin
            n_err++;
            $display("FAIL basic_ready: got busy_ready=%0d rdy6=%b done6=%b want 0 1 0", busy, cap_ready[6], cap_done[6]);
        end
        n_cmp++;
        if (cap_s[1] !== 2'b01 || cap_s[5] !== 2'b10) begin
            n_err++;
            $display("FAIL basic_state: got S1=%b S5=%b want 01 10", cap_s[1], cap_s[5]);
        end
    endtask

    task automatic test_repeat();
        int gaps;
        int hits;
        logic [2:0] win;
        run_xfer(16'h0006, 5'd3, 4'd2, 99, 0, 0, 16'h0000);
        n_cmp++;
        if (cap_bits !== 80'h1B6 || cap_nbits != 9) begin
            n_err++;
            $display("FAIL repeat_bits: got %h/%0d want 1b6/9", cap_bits, cap_nbits);
        end
        gaps = 0;
        for (int k = 1; k <= 9; k++) if (cap_valid[k] !== 1'b1) gaps++;
        n_cmp++;
        if (gaps != 0 || cap_done_cyc != 10) begin
            n_err++;
            $display("FAIL repeat_timing: got gaps=%0d done=%0d want 0 10", gaps, cap_done_cyc);
        end
        // Reference 110 detector over the captured stream.
        hits = 0;
        win  = 3'b000;
        for (int i = 8; i >= 0; i--) begin
            win = {win[1:0], cap_bits[i]};
            if (i <= 6 && win == 3'b110) hits++;
        end
        n_cmp++;
        if (hits != 3) begin
            n_err++;
            $display("FAIL repeat_detect110: got %0d want 3", hits);
        end
    endtask

    task automatic test_hold();
        int bad;
        run_xfer(16'h000B, 5'd4, 4'd0, 2, 3, 0, 16'h0000);
        n_cmp++;
        if (cap_bits !== 80'hB || cap_nbits != 4) begin
            n_err++;
            $display("FAIL hold_bits: got %h/%0d want b/4", cap_bits, cap_nbits);
        end
        n_cmp++;
        if (cap_done_cyc != 8) begin
            n_err++;
            $display("FAIL hold_done_cycle: got %0d want 8", cap_done_cyc);
        end
        bad = 0;
        for (int k = 3; k <= 5; k++) if (cap_valid[k] !== 1'b0 || cap_x[k] !== 1'b0 || cap_s[k] !== 2'b01) bad++;
        n_cmp++;
        if (bad != 0 || cap_valid[6] !== 1'b1 || cap_x[6] !== 1'b1) begin
            n_err++;
            $display("FAIL hold_gap: got bad=%0d v6=%b x6=%b want 0 1 1", bad, cap_valid[6], cap_x[6]);
        end
    endtask

    task automatic test_bounds();
        int pulses;
        run_xfer(16'hFFFF, 5'd0, 4'd3, 99, 0, 0, 16'h0000);
        pulses = 0;
        for (int k = 1; k <= cap_last; k++) pulses += int'(cap_done[k]);
        n_cmp++;
        if (cap_done_cyc != 1 || cap_nbits != 0 || pulses != 1) begin
            n_err++;
            $display("FAIL zero_len: got done=%0d bits=%0d pulses=%0d want 1 0 1", cap_done_cyc, cap_nbits, pulses);
        end
        n_cmp++;
        if (cap_s[1] !== 2'b10 || cap_ready[2] !== 1'b1) begin
            n_err++;
            $display("FAIL zero_len_state: got S1=%b rdy2=%b want 10 1", cap_s[1], cap_ready[2]);
        end
        run_xfer(16'hA5C3, 5'd20, 4'd0, 99, 0, 0, 16'h0000);
        n_cmp++;
        if (cap_bits !== 80'hA5C3 || cap_nbits != 16 || cap_done_cyc != 17) begin
            n_err++;
            $display("FAIL clamp_len: got %h/%0d done=%0d want a5c3/16 done=17", cap_bits, cap_nbits, cap_done_cyc);
        end
    endtask

    task automatic test_load_ignored();
        run_xfer(16'h000B, 5'd4, 4'd0, 99, 0, 2, 16'h0004);
        n_cmp++;
        if (cap_bits !== 80'hB || cap_nbits != 4 || cap_done_cyc != 5) begin
            n_err++;
            $display("FAIL load_busy: got %h/%0d done=%0d want b/4 done=5", cap_bits, cap_nbits, cap_done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        run_xfer(16'h0001, 5'd1, 4'd3, 99, 0, 0, 16'h0000);
        n_cmp++;
        if (cap_bits !== 80'hF || cap_nbits != 4 || cap_done_cyc != 5) begin
            n_err++;
            $display("FAIL len1_repeat: got %h/%0d done=%0d want f/4 done=5", cap_bits, cap_nbits, cap_done_cyc);
        end
        run_xfer(16'h0002, 5'd2, 4'd1, 99, 0, 0, 16'h0000);
        n_cmp++;
        if (cap_bits !== 80'hA || cap_nbits != 4 || cap_done_cyc != 5) begin
            n_err++;
            $display("FAIL back_to_back: got %h/%0d done=%0d want a/4 done=5", cap_bits, cap_nbits, cap_done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        load    = 1'b1;
        pattern = 16'h000F;
        length  = 5'd4;
        rep     = 4'd2;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (xv !== 1'b1 || x !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pre: got xv=%b x=%b want 1 1", xv, x);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready, x, xv, done, s} !== 6'b100000) begin
            n_err++;
            $display("FAIL midreset_async: got rdy,x,xv,done,S=%b want 100000", {ready, x, xv, done, s});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || done !== 1'b0 || s !== 2'b00) begin
            n_err++;
            $display("FAIL midreset_idle: got ready=%b done=%b S=%b want 1 0 00", ready, done, s);
        end
        run_xfer(16'h000B, 5'd4, 4'd0, 99, 0, 0, 16'h0000);
        n_cmp++;
        if (cap_bits !== 80'hB || cap_nbits != 4 || cap_done_cyc != 5) begin
            n_err++;
            $display("FAIL midreset_reload: got %h/%0d done=%0d want b/4 done=5", cap_bits, cap_nbits, cap_done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_hold();
        test_bounds();
        test_load_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
